idma_legalizer_burst_split: RTL and testbench

Parametrised successor of the single-beat legalizer. Splits one generic 1D transfer (length, src, dst) into legal read and write chunks. Each chunk is bounded by a configurable page size and a configurable maximum burst size, so one chunk can span many data-path words instead of one. Sits between the 1D midend/frontend and the read/write managers, and drives read and write chunk streams with registered, protocol-compliant valid/ready handshakes.

---
 rtl/idma_legalizer_burst_split_pkg.sv | 26 ++
 rtl/idma_legalizer_bound_calc.sv | 16 +
 rtl/idma_legalizer_burst_split.sv | 215 +++++++++++++++++++++
 tb/tb_idma_legalizer_burst_split.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_legalizer_burst_split_pkg.sv
// Shared types and derived-size helpers for the burst-splitting legalizer.
package idma_legalizer_burst_split_pkg;

  // Per-side machine state: IDLE holds no bytes, ACTIVE still has bytes to emit.
  typedef enum logic [0:0] {
    SIDE_IDLE   = 1'b0,
    SIDE_ACTIVE = 1'b1
  } side_state_e;

  // Chunk boundary: the tighter of the page size and the maximum burst size.
  function automatic int unsigned calc_bnd(input int unsigned page_size,
                                           input int unsigned max_burst);
    if (page_size < max_burst) begin
      return page_size;
    end else begin
      return max_burst;
    end
  endfunction

  // Chunk length width: enough bits to hold a full boundary-sized chunk.
  function automatic int unsigned calc_cw(input int unsigned page_size,
                                          input int unsigned max_burst);
    return $clog2(calc_bnd(page_size, max_burst)) + 1;
  endfunction

endpackage

// File: rtl/idma_legalizer_bound_calc.sv
// Distance in bytes from an address to the next chunk boundary (1..Bnd).
module idma_legalizer_bound_calc #(
  parameter int unsigned Bnd = 16,
  localparam int unsigned BndWidth = $clog2(Bnd),
  localparam int unsigned Cw = BndWidth + 1
) (
  input  logic [BndWidth-1:0] addr_low,
  output logic [Cw-1:0]       to_bound
);

  // Only the in-boundary offset matters; an aligned address yields a full boundary.
  always_comb begin
    to_bound = Cw'(Bnd) - {1'b0, addr_low};
  end

endmodule

// File: rtl/idma_legalizer_burst_split.sv
// Splits a 1D transfer into boundary-legal read and write chunk streams.
module idma_legalizer_burst_split
  import idma_legalizer_burst_split_pkg::*;
#(
  parameter int unsigned DataWidth       = 32,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned LenWidth        = 32,
  parameter int unsigned PageSize        = 4096,
  parameter int unsigned MaxBurstBytes   = 256,
  parameter bit          CombinedShifter = 1'b0,
  localparam int unsigned StrbWidth   = DataWidth / 8,
  localparam int unsigned OffsetWidth = $clog2(StrbWidth),
  localparam int unsigned Bnd         = calc_bnd(PageSize, MaxBurstBytes),
  localparam int unsigned BndWidth    = $clog2(Bnd),
  localparam int unsigned CW          = calc_cw(PageSize, MaxBurstBytes)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [LenWidth-1:0]    req_length_i,
  input  logic [AddrWidth-1:0]   req_src_addr_i,
  input  logic [AddrWidth-1:0]   req_dst_addr_i,
  input  logic                   req_decouple_i,
  input  logic                   req_super_last_i,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [AddrWidth-1:0]   r_addr_o,
  output logic [CW-1:0]          r_num_bytes_o,
  output logic [OffsetWidth-1:0] r_offset_o,
  output logic [OffsetWidth-1:0] r_tailer_o,
  output logic [OffsetWidth-1:0] r_shift_o,
  output logic                   r_last_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  output logic [AddrWidth-1:0]   w_addr_o,
  output logic [CW-1:0]          w_num_bytes_o,
  output logic [OffsetWidth-1:0] w_offset_o,
  output logic [OffsetWidth-1:0] w_tailer_o,
  output logic [OffsetWidth-1:0] w_shift_o,
  output logic                   w_last_o,
  output logic                   w_super_last_o,
  input  logic                   kill_i,
  input  logic                   flush_i,
  output logic                   r_busy_o,
  output logic                   w_busy_o
);

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic [CW-1:0]          num_bytes;
    logic [OffsetWidth-1:0] offset;
    logic [OffsetWidth-1:0] tailer;
    logic [OffsetWidth-1:0] shift;
    logic                   last;
  } chunk_t;

  typedef struct packed {
    side_state_e          state;
    logic [AddrWidth-1:0] addr;
    logic [LenWidth-1:0]  rem;
    logic                 valid;
  } side_t;

  localparam side_t SideIdle = '{state: SIDE_IDLE, addr: '0, rem: '0, valid: 1'b0};

  side_t                  r_side_r, w_side_r;
  logic                   decouple_r, super_last_r;
  logic [OffsetWidth-1:0] r_shift_r, w_shift_r;
  logic [BndWidth-1:0]    delta_r;

  logic [BndWidth-1:0]    r_peer_low_s, w_peer_low_s;
  logic [CW-1:0]          r_tb_s, w_tb_s, r_peer_tb_s, w_peer_tb_s;
  logic [CW-1:0]          r_poss_s, w_poss_s;
  chunk_t                 r_chunk_s, w_chunk_s;
  logic                   req_hs_s, r_hs_s, w_hs_s;

  // Build the pending chunk of one side from its position, allowance and shift.
  function automatic chunk_t make_chunk(input logic [AddrWidth-1:0]   addr,
                                        input logic [LenWidth-1:0]    rem,
                                        input logic [CW-1:0]          poss,
                                        input logic [OffsetWidth-1:0] shift);
    chunk_t c;
    c.addr      = addr;
    c.last      = (rem <= LenWidth'(poss));
    c.num_bytes = c.last ? rem[CW-1:0] : poss;
    c.offset    = addr[OffsetWidth-1:0];
    c.tailer    = c.num_bytes[OffsetWidth-1:0] + c.offset;
    c.shift     = shift;
    return c;
  endfunction

  // Step one side after a possible handshake; the last chunk returns it to IDLE.
  function automatic side_t advance(input side_t cur, input logic hs, input chunk_t c);
    side_t nxt;
    nxt = cur;
    case (cur.state)
      SIDE_IDLE: nxt = cur;
      SIDE_ACTIVE: begin
        if (hs) begin
          nxt.addr = cur.addr + AddrWidth'(c.num_bytes);
          nxt.rem  = cur.rem - LenWidth'(c.num_bytes);
          if (c.last) begin
            nxt.state = SIDE_IDLE;
            nxt.valid = 1'b0;
          end else begin
            nxt.state = SIDE_ACTIVE;
          end
        end else begin
          nxt = cur;
        end
      end
      default: nxt = SideIdle;
    endcase
    return nxt;
  endfunction

  // In coupled mode each side tracks where its partner stands after the same
  // number of bytes, so equal chunk sizes hold even when the sides drift apart.
  assign r_peer_low_s = r_side_r.addr[BndWidth-1:0] + delta_r;
  assign w_peer_low_s = w_side_r.addr[BndWidth-1:0] - delta_r;

  idma_legalizer_bound_calc #(.Bnd(Bnd)) i_r_bound (
    .addr_low(r_side_r.addr[BndWidth-1:0]), .to_bound(r_tb_s));
  idma_legalizer_bound_calc #(.Bnd(Bnd)) i_w_bound (
    .addr_low(w_side_r.addr[BndWidth-1:0]), .to_bound(w_tb_s));
  idma_legalizer_bound_calc #(.Bnd(Bnd)) i_r_peer_bound (
    .addr_low(r_peer_low_s), .to_bound(r_peer_tb_s));
  idma_legalizer_bound_calc #(.Bnd(Bnd)) i_w_peer_bound (
    .addr_low(w_peer_low_s), .to_bound(w_peer_tb_s));

  // Size each pending chunk from its own boundary or the tighter of the pair.
  always_comb begin
    r_poss_s = r_tb_s;
    w_poss_s = w_tb_s;
    if (decouple_r) begin
      r_poss_s = r_tb_s;
      w_poss_s = w_tb_s;
    end else begin
      r_poss_s = (r_peer_tb_s < r_tb_s) ? r_peer_tb_s : r_tb_s;
      w_poss_s = (w_peer_tb_s < w_tb_s) ? w_peer_tb_s : w_tb_s;
    end
    r_chunk_s = make_chunk(r_side_r.addr, r_side_r.rem, r_poss_s, r_shift_r);
    w_chunk_s = make_chunk(w_side_r.addr, w_side_r.rem, w_poss_s, w_shift_r);
  end

  assign r_busy_o    = (r_side_r.state == SIDE_ACTIVE);
  assign w_busy_o    = (w_side_r.state == SIDE_ACTIVE);
  assign req_ready_o = ~r_busy_o & ~w_busy_o & ~kill_i & ~flush_i;
  assign req_hs_s    = req_valid_i & req_ready_o;
  assign r_valid_o   = r_side_r.valid & ~flush_i;
  assign w_valid_o   = w_side_r.valid & ~flush_i;
  assign r_hs_s      = r_valid_o & r_ready_i;
  assign w_hs_s      = w_valid_o & w_ready_i;

  assign r_addr_o       = r_chunk_s.addr;
  assign r_num_bytes_o  = r_chunk_s.num_bytes;
  assign r_offset_o     = r_chunk_s.offset;
  assign r_tailer_o     = r_chunk_s.tailer;
  assign r_shift_o      = r_chunk_s.shift;
  assign r_last_o       = r_chunk_s.last & r_side_r.valid;
  assign w_addr_o       = w_chunk_s.addr;
  assign w_num_bytes_o  = w_chunk_s.num_bytes;
  assign w_offset_o     = w_chunk_s.offset;
  assign w_tailer_o     = w_chunk_s.tailer;
  assign w_shift_o      = w_chunk_s.shift;
  assign w_last_o       = w_chunk_s.last & w_side_r.valid;
  assign w_super_last_o = super_last_r;

  // Run both chunk machines and latch the per-transfer context on acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_side_r     <= SideIdle;
      w_side_r     <= SideIdle;
      decouple_r   <= 1'b0;
      super_last_r <= 1'b0;
      r_shift_r    <= '0;
      w_shift_r    <= '0;
      delta_r      <= '0;
    end else if (kill_i) begin
      r_side_r <= SideIdle;
      w_side_r <= SideIdle;
    end else if (req_hs_s) begin
      r_side_r.addr  <= req_src_addr_i;
      r_side_r.rem   <= req_length_i;
      w_side_r.addr  <= req_dst_addr_i;
      w_side_r.rem   <= req_length_i;
      decouple_r     <= req_decouple_i;
      super_last_r   <= req_super_last_i;
      delta_r        <= req_dst_addr_i[BndWidth-1:0] - req_src_addr_i[BndWidth-1:0];
      if (req_length_i == '0) begin
        r_side_r.state <= SIDE_IDLE;
        r_side_r.valid <= 1'b0;
        w_side_r.state <= SIDE_IDLE;
        w_side_r.valid <= 1'b0;
      end else begin
        r_side_r.state <= SIDE_ACTIVE;
        r_side_r.valid <= 1'b1;
        w_side_r.state <= SIDE_ACTIVE;
        w_side_r.valid <= 1'b1;
      end
      if (CombinedShifter) begin
        r_shift_r <= req_src_addr_i[OffsetWidth-1:0] - req_dst_addr_i[OffsetWidth-1:0];
        w_shift_r <= '0;
      end else begin
        r_shift_r <= req_src_addr_i[OffsetWidth-1:0];
        w_shift_r <= '0 - req_dst_addr_i[OffsetWidth-1:0];
      end
    end else begin
      r_side_r <= advance(r_side_r, r_hs_s, r_chunk_s);
      w_side_r <= advance(w_side_r, w_hs_s, w_chunk_s);
    end
  end

endmodule

// File: tb/tb_idma_legalizer_burst_split.sv
// Randomized self-checking bench for the burst-splitting legalizer.
module tb_idma_legalizer_burst_split;

  logic        clk_i, rst_i;
  logic        req_valid_i, req_ready_o;
  logic [31:0] req_length_i, req_src_addr_i, req_dst_addr_i;
  logic        req_decouple_i, req_super_last_i;
  logic        r_valid_o, r_ready_i, r_last_o;
  logic [31:0] r_addr_o;
  logic [4:0]  r_num_bytes_o;
  logic [1:0]  r_offset_o, r_tailer_o, r_shift_o;
  logic        w_valid_o, w_ready_i, w_last_o, w_super_last_o;
  logic [31:0] w_addr_o;
  logic [4:0]  w_num_bytes_o;
  logic [1:0]  w_offset_o, w_tailer_o, w_shift_o;
  logic        kill_i, flush_i, r_busy_o, w_busy_o;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  num;
    logic        last;
  } exp_t;

  exp_t rq[$];
  exp_t wq[$];

  idma_legalizer_burst_split #(
    .DataWidth(32), .AddrWidth(32), .LenWidth(32),
    .PageSize(64), .MaxBurstBytes(16), .CombinedShifter(1'b0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_length_i(req_length_i), .req_src_addr_i(req_src_addr_i),
    .req_dst_addr_i(req_dst_addr_i), .req_decouple_i(req_decouple_i),
    .req_super_last_i(req_super_last_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_addr_o(r_addr_o),
    .r_num_bytes_o(r_num_bytes_o), .r_offset_o(r_offset_o), .r_tailer_o(r_tailer_o),
    .r_shift_o(r_shift_o), .r_last_o(r_last_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_addr_o(w_addr_o),
    .w_num_bytes_o(w_num_bytes_o), .w_offset_o(w_offset_o), .w_tailer_o(w_tailer_o),
    .w_shift_o(w_shift_o), .w_last_o(w_last_o), .w_super_last_o(w_super_last_o),
    .kill_i(kill_i), .flush_i(flush_i), .r_busy_o(r_busy_o), .w_busy_o(w_busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: walk the transfer byte by byte-offset, cutting at 16-byte boundaries.
  task automatic build_model(input int unsigned len, input logic [31:0] src,
                             input logic [31:0] dst, input logic dec);
    logic [31:0] ra, wa;
    int unsigned k, rt, wt, p, n;
    rq.delete();
    wq.delete();
    if (dec) begin
      k = 0;
      while (k < len) begin
        ra = src + k;
        rt = 16 - (ra % 16);
        n  = (len - k < rt) ? len - k : rt;
        rq.push_back('{ra, 5'(n), (k + n == len)});
        k += n;
      end
      k = 0;
      while (k < len) begin
        wa = dst + k;
        wt = 16 - (wa % 16);
        n  = (len - k < wt) ? len - k : wt;
        wq.push_back('{wa, 5'(n), (k + n == len)});
        k += n;
      end
    end else begin
      k = 0;
      while (k < len) begin
        ra = src + k;
        wa = dst + k;
        rt = 16 - (ra % 16);
        wt = 16 - (wa % 16);
        p  = (rt < wt) ? rt : wt;
        n  = (len - k < p) ? len - k : p;
        rq.push_back('{ra, 5'(n), (k + n == len)});
        wq.push_back('{wa, 5'(n), (k + n == len)});
        k += n;
      end
    end
  endtask

  task automatic send_req(input int unsigned len, input logic [31:0] src,
                          input logic [31:0] dst, input logic dec, input logic sl);
    int wait_cyc;
    wait_cyc = 0;
    @(negedge clk_i);
    req_length_i = len; req_src_addr_i = src; req_dst_addr_i = dst;
    req_decouple_i = dec; req_super_last_i = sl; req_valid_i = 1'b1;
    #1;
    while (req_ready_o !== 1'b1 && wait_cyc < 50) begin
      @(negedge clk_i); #1;
      wait_cyc++;
    end
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL req_accept: req_ready_o=%b required 1", req_ready_o);
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    total++;
    if (r_valid_o !== (len != 0) || w_valid_o !== (len != 0)) begin
      bad++;
      $display("FAIL latency: r_valid=%b w_valid=%b required %b", r_valid_o, w_valid_o, len != 0);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: write stall on chunk 2, 3: flush on read chunk 2
  task automatic run_transfer(input int unsigned len, input logic [31:0] src,
                              input logic [31:0] dst, input logic dec, input logic sl,
                              input int mode);
    exp_t e;
    int cyc, ri, wi, hold, fl;
    logic stall_prev, r_first;
    logic [43:0] saved, now_w;
    logic [1:0] r_sh, w_sh, tl;
    r_sh = src[1:0];
    w_sh = 2'd0 - dst[1:0];
    cyc = 0; ri = 0; wi = 0; hold = 0; fl = 0;
    stall_prev = 1'b0; r_first = 1'b0; saved = '0;
    build_model(len, src, dst, dec);
    send_req(len, src, dst, dec, sl);
    while ((rq.size() > 0 || wq.size() > 0) && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
      flush_i = (mode == 3 && ri == 1 && fl < 3);
      if (flush_i) fl++;
      r_ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 1) begin
        w_ready_i = 1'($urandom_range(0, 1));
      end else if (mode == 2 && wi == 1 && hold < 5) begin
        w_ready_i = 1'b0;
        hold++;
      end else begin
        w_ready_i = 1'b1;
      end
      #1;
      total++;
      if (r_busy_o !== (rq.size() > 0) || w_busy_o !== (wq.size() > 0) || req_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL busy: r_busy=%b w_busy=%b req_ready=%b required %b %b 0",
                 r_busy_o, w_busy_o, req_ready_o, rq.size() > 0, wq.size() > 0);
      end
      if (flush_i) begin
        total++;
        if (r_valid_o !== 1'b0 || w_valid_o !== 1'b0 || r_addr_o !== rq[0].addr) begin
          bad++;
          $display("FAIL flush_hold: r_valid=%b w_valid=%b r_addr=%h required 0 0 %h",
                   r_valid_o, w_valid_o, r_addr_o, rq[0].addr);
        end
      end
      now_w = {w_addr_o, w_num_bytes_o, w_last_o, w_offset_o, w_tailer_o, w_shift_o};
      if (stall_prev) begin
        total++;
        if (w_valid_o !== 1'b1 || now_w !== saved) begin
          bad++;
          $display("FAIL w_stable: valid=%b fields=%h required 1 %h", w_valid_o, now_w, saved);
        end
      end
      if (r_valid_o && r_ready_i) begin
        total++;
        if (rq.size() == 0) begin
          bad++;
          $display("FAIL r_extra: addr=%h required no chunk", r_addr_o);
        end else begin
          e = rq.pop_front();
          tl = e.addr[1:0] + e.num[1:0];
          if ({r_addr_o, r_num_bytes_o, r_last_o, r_offset_o, r_tailer_o, r_shift_o} !==
              {e.addr, e.num, e.last, e.addr[1:0], tl, r_sh}) begin
            bad++;
            $display("FAIL r_chunk: got a=%h n=%0d l=%b o=%0d t=%0d s=%0d required a=%h n=%0d l=%b o=%0d t=%0d s=%0d",
                     r_addr_o, r_num_bytes_o, r_last_o, r_offset_o, r_tailer_o, r_shift_o,
                     e.addr, e.num, e.last, e.addr[1:0], tl, r_sh);
          end
          ri++;
        end
      end
      if (w_valid_o && w_ready_i) begin
        total++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL w_extra: addr=%h required no chunk", w_addr_o);
        end else begin
          e = wq.pop_front();
          tl = e.addr[1:0] + e.num[1:0];
          if ({w_addr_o, w_num_bytes_o, w_last_o, w_offset_o, w_tailer_o, w_shift_o, w_super_last_o} !==
              {e.addr, e.num, e.last, e.addr[1:0], tl, w_sh, sl}) begin
            bad++;
            $display("FAIL w_chunk: got a=%h n=%0d l=%b o=%0d t=%0d s=%0d sl=%b required a=%h n=%0d l=%b o=%0d t=%0d s=%0d sl=%b",
                     w_addr_o, w_num_bytes_o, w_last_o, w_offset_o, w_tailer_o, w_shift_o, w_super_last_o,
                     e.addr, e.num, e.last, e.addr[1:0], tl, w_sh, sl);
          end
          wi++;
        end
      end
      stall_prev = w_valid_o && !w_ready_i;
      saved = now_w;
      if (rq.size() == 0 && wq.size() > 0) r_first = 1'b1;
    end
    flush_i = 1'b0;
    if (cyc >= 300) begin
      total++; bad++;
      $display("FAIL timeout: %0d read and %0d write chunks outstanding, required 0", rq.size(), wq.size());
    end
    if (mode == 2) begin
      total++;
      if (r_first !== 1'b1) begin
        bad++;
        $display("FAIL read_independent: read finished first=%b required 1", r_first);
      end
    end
    @(negedge clk_i); #1;
    total++;
    if (req_ready_o !== 1'b1 || r_busy_o !== 1'b0 || w_busy_o !== 1'b0 || r_valid_o !== 1'b0 || w_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL done_idle: ready=%b busy=%b%b valid=%b%b required 1 00 00",
               req_ready_o, r_busy_o, w_busy_o, r_valid_o, w_valid_o);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    total++;
    if ({r_valid_o, w_valid_o, r_busy_o, w_busy_o, r_last_o, w_last_o, w_super_last_o} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b%b busy=%b%b last=%b%b sl=%b required all 0",
               r_valid_o, w_valid_o, r_busy_o, w_busy_o, r_last_o, w_last_o, w_super_last_o);
    end
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: req_ready_o=%b required 1", req_ready_o);
    end
  endtask

  task automatic test_reset_mid;
    r_ready_i = 1'b1; w_ready_i = 1'b1;
    send_req(40, 32'h06, 32'h21, 1'b1, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    total++;
    if ({r_valid_o, w_valid_o, r_busy_o, w_busy_o, r_last_o, w_last_o, req_ready_o} !== 7'b0000001) begin
      bad++;
      $display("FAIL reset_mid: valid=%b%b busy=%b%b last=%b%b ready=%b required 000000 1",
               r_valid_o, w_valid_o, r_busy_o, w_busy_o, r_last_o, w_last_o, req_ready_o);
    end
  endtask

  task automatic test_kill;
    r_ready_i = 1'b1; w_ready_i = 1'b1;
    send_req(40, 32'h06, 32'h21, 1'b1, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    kill_i = 1'b1;
    #1;
    total++;
    if (r_addr_o !== 32'h10) begin
      bad++;
      $display("FAIL kill_setup: r_addr=%h required 00000010", r_addr_o);
    end
    @(negedge clk_i);
    kill_i = 1'b0;
    #1;
    total++;
    if (r_busy_o !== 1'b0 || w_busy_o !== 1'b0 || r_valid_o !== 1'b0 || w_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL kill_idle: busy=%b%b valid=%b%b required 00 00", r_busy_o, w_busy_o, r_valid_o, w_valid_o);
    end
    @(negedge clk_i); #1;
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL kill_ready: req_ready_o=%b required 1", req_ready_o);
    end
  endtask

  task automatic test_zero_len;
    r_ready_i = 1'b1; w_ready_i = 1'b1;
    send_req(0, 32'h40, 32'h80, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); #1;
      total++;
      if (r_valid_o !== 1'b0 || w_valid_o !== 1'b0 || r_busy_o !== 1'b0 || w_busy_o !== 1'b0) begin
        bad++;
        $display("FAIL zero_len: valid=%b%b busy=%b%b required 00 00", r_valid_o, w_valid_o, r_busy_o, w_busy_o);
      end
    end
    run_transfer(4, 32'h40, 32'h80, 1'b0, 1'b1, 0);
  endtask

  task automatic test_random;
    int unsigned len;
    logic [31:0] src, dst;
    for (int i = 0; i < 30; i++) begin
      len = $urandom_range(0, 150);
      src = (i % 5 == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63))) : 32'($urandom_range(0, 1023));
      dst = $urandom();
      run_transfer(len, src, dst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    end
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_length_i = '0; req_src_addr_i = '0;
    req_dst_addr_i = '0; req_decouple_i = 1'b0; req_super_last_i = 1'b0;
    r_ready_i = 1'b0; w_ready_i = 1'b0; kill_i = 1'b0; flush_i = 1'b0;
    test_reset();
    run_transfer(40, 32'h06, 32'h21, 1'b1, 1'b0, 0);
    run_transfer(40, 32'h06, 32'h21, 1'b0, 1'b1, 0);
    run_transfer(40, 32'h06, 32'h21, 1'b1, 1'b0, 2);
    test_kill();
    run_transfer(40, 32'h06, 32'h21, 1'b1, 1'b0, 3);
    test_zero_len();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
